// File: rtl/seg7_num_display_if.sv
// Request/result bundle between a requester and seg7_num_display.
// The master drives a value to show; the slave returns the 7-segment digits.
interface seg7_num_display_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_DIGITS = 6
);
  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_WIDTH-1:0]   in_data;
  logic                    in_hex;
  logic                    busy;
  logic                    done;
  logic                    ovf;
  logic [7*NUM_DIGITS-1:0] hex;

  modport master (
    output in_valid, in_data, in_hex,
    input  in_ready, busy, done, ovf, hex
  );

  modport slave (
    input  in_valid, in_data, in_hex,
    output in_ready, busy, done, ovf, hex
  );
endinterface

// File: rtl/seg7_num_display.sv
// Sequential binary-to-decimal (double dabble) or raw-hex converter driving
// NUM_DIGITS active-low 7-segment digits, with sign, blanking and overflow.
module seg7_num_display #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_DIGITS = 6,
  parameter bit SIGNED     = 1'b0,
  parameter bit BLANK_LZ   = 1'b0
) (
  input logic               clk,
  input logic               rst,
  seg7_num_display_if.slave bus
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int HEX_W = 7 * NUM_DIGITS;
  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    UPDATE
  } state_t;

  state_t state, state_n;

  logic [DATA_WIDTH-1:0] mag, mag_n;
  logic [BCD_W-1:0]      bcd, bcd_n, bcd_adj;
  logic [CNT_W-1:0]      cnt, cnt_n;
  logic                  hex_mode, hex_mode_n;
  logic                  neg, neg_n;
  logic                  ovf_int, ovf_int_n;
  logic [HEX_W-1:0]      hex_r, hex_n;
  logic                  ovf_r, ovf_n;
  logic                  done_r, done_n;

  logic [HEX_W-1:0]      glyphs;
  logic                  sign_ovf;
  int                    msd;
  int                    minus_pos;

  function automatic logic [6:0] seg_encode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    logic [3:0]       nib;
    r = b;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      nib = b[4*i +: 4];
      if (nib >= 4'd5) r[4*i +: 4] = nib + 4'd3;
    end
    return r;
  endfunction

  // Turn the finished BCD/hex nibbles into glyphs, applying blanking and sign placement
  always_comb begin
    msd       = 0;
    sign_ovf  = 1'b0;
    minus_pos = NUM_DIGITS - 1;
    glyphs    = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd[4*i +: 4] != 4'd0) msd = i;
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      glyphs[7*i +: 7] = seg_encode(bcd[4*i +: 4]);
      if (!hex_mode && BLANK_LZ && (i > msd)) glyphs[7*i +: 7] = SEG_BLANK;
    end
    if (!hex_mode && neg) begin
      if (BLANK_LZ) minus_pos = msd + 1;
      // No free digit left of the magnitude: minus takes the top digit and flags overflow
      if (msd == NUM_DIGITS - 1) begin
        minus_pos = NUM_DIGITS - 1;
        sign_ovf  = 1'b1;
      end
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (i == minus_pos) glyphs[7*i +: 7] = SEG_MINUS;
      end
    end
  end

  always_comb begin
    state_n    = state;
    mag_n      = mag;
    bcd_n      = bcd;
    cnt_n      = cnt;
    hex_mode_n = hex_mode;
    neg_n      = neg;
    ovf_int_n  = ovf_int;
    hex_n      = hex_r;
    ovf_n      = ovf_r;
    done_n     = 1'b0;
    bcd_adj    = bcd;

    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          hex_mode_n = bus.in_hex;
          neg_n      = SIGNED && !bus.in_hex && bus.in_data[DATA_WIDTH-1];
          // Negating the most negative value wraps to its correct unsigned magnitude
          mag_n      = neg_n ? (~bus.in_data) + DATA_WIDTH'(1) : bus.in_data;
          bcd_n      = '0;
          cnt_n      = CNT_W'(DATA_WIDTH);
          ovf_int_n  = 1'b0;
          state_n    = SHIFT;
        end
      end
      SHIFT: begin
        bcd_adj   = hex_mode ? bcd : add3(bcd);
        bcd_n     = {bcd_adj[BCD_W-2:0], mag[DATA_WIDTH-1]};
        mag_n     = {mag[DATA_WIDTH-2:0], 1'b0};
        ovf_int_n = ovf_int | bcd_adj[BCD_W-1];
        cnt_n     = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_n = UPDATE;
      end
      UPDATE: begin
        hex_n   = glyphs;
        ovf_n   = ovf_int | sign_ovf;
        done_n  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      mag      <= '0;
      bcd      <= '0;
      cnt      <= '0;
      hex_mode <= 1'b0;
      neg      <= 1'b0;
      ovf_int  <= 1'b0;
      hex_r    <= '1;
      ovf_r    <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state    <= state_n;
      mag      <= mag_n;
      bcd      <= bcd_n;
      cnt      <= cnt_n;
      hex_mode <= hex_mode_n;
      neg      <= neg_n;
      ovf_int  <= ovf_int_n;
      hex_r    <= hex_n;
      ovf_r    <= ovf_n;
      done_r   <= done_n;
    end
  end

  assign bus.in_ready = (state == IDLE);
  assign bus.busy     = (state != IDLE);
  assign bus.done     = done_r;
  assign bus.ovf      = ovf_r;
  assign bus.hex      = hex_r;

endmodule

// File: tb/tb_seg7_num_display.sv
// Bench for seg7_num_display: an unsigned/zero-padded instance and a signed/blanking
// instance run in lockstep on the same requests and are checked against hand-written digits.
module tb_seg7_num_display;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  seg7_num_display_if #(.DATA_WIDTH(32), .NUM_DIGITS(6)) bu ();
  seg7_num_display_if #(.DATA_WIDTH(32), .NUM_DIGITS(6)) bs ();

  seg7_num_display #(.DATA_WIDTH(32), .NUM_DIGITS(6), .SIGNED(1'b0), .BLANK_LZ(1'b0)) dut_u (
    .clk (clk),
    .rst (rst),
    .bus (bu.slave)
  );

  seg7_num_display #(.DATA_WIDTH(32), .NUM_DIGITS(6), .SIGNED(1'b1), .BLANK_LZ(1'b1)) dut_s (
    .clk (clk),
    .rst (rst),
    .bus (bs.slave)
  );

  typedef struct {
    logic [31:0] data;
    logic        hx;
    string       exp_u;
    logic        ovf_u;
    string       exp_s;
    logic        ovf_s;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  // Characters are written most significant digit first: "-" minus, " " blank
  function automatic logic [6:0] glyph(input byte c);
    logic [6:0] s;
    case (c)
      "0":      s = 7'b1000000;
      "1":      s = 7'b1111001;
      "2":      s = 7'b0100100;
      "3":      s = 7'b0110000;
      "4":      s = 7'b0011001;
      "5":      s = 7'b0010010;
      "6":      s = 7'b0000010;
      "7":      s = 7'b1111000;
      "8":      s = 7'b0000000;
      "9":      s = 7'b0010000;
      "A":      s = 7'b0001000;
      "b":      s = 7'b0000011;
      "C":      s = 7'b1000110;
      "d":      s = 7'b0100001;
      "E":      s = 7'b0000110;
      "F":      s = 7'b0001110;
      " ":      s = 7'b1111111;
      "-":      s = 7'b0111111;
      default:  s = 7'b1010101;
    endcase
    return s;
  endfunction

  function automatic logic [41:0] expect_hex(input string s);
    logic [41:0] r;
    r = '0;
    for (int i = 0; i < 6; i++) r[7*i +: 7] = glyph(s[5-i]);
    return r;
  endfunction

  task automatic add_vec(input logic [31:0] d, input logic h, input string eu, input logic ou,
                         input string es, input logic os);
    vec_t v;
    v.data = d; v.hx = h; v.exp_u = eu; v.ovf_u = ou; v.exp_s = es; v.ovf_s = os;
    vecs.push_back(v);
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0b, expected %0b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_output(input string name, input logic [41:0] act, input string exp);
    checks++;
    if (act !== expect_hex(exp)) begin
      errors++;
      $display("[TB] FAIL %s: got hex=%h, expected hex=%h (\"%s\")", name, act, expect_hex(exp), exp);
    end
  endtask

  task automatic set_in(input logic v, input logic [31:0] d, input logic h);
    bu.in_valid = v; bu.in_data = d; bu.in_hex = h;
    bs.in_valid = v; bs.in_data = d; bs.in_hex = h;
  endtask

  // Presents one request in an idle cycle; returns just after the accept edge
  task automatic apply_stimulus(input logic [31:0] d, input logic h);
    @(negedge clk);
    set_in(1'b1, d, h);
    @(posedge clk);
    #1;
    set_in(1'b0, 32'd0, 1'b0);
  endtask

  task automatic wait_done(input string name);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      #1;
      if (bu.done) begin
        got = 1'b1;
        break;
      end
    end
    check_bit({name, "_done_seen"}, got, 1'b1);
    check_bit({name, "_done_lockstep"}, bs.done, 1'b1);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int busy_cnt;
    int done_edge;
    int ndone;
    int done_at[3];
    bit prev_done;

    add_vec(32'd29,         1'b0, "000029", 1'b0, "    29", 1'b0);
    add_vec(32'd1234567,    1'b0, "234567", 1'b1, "234567", 1'b1);
    add_vec(32'd888,        1'b0, "000888", 1'b0, "   888", 1'b0);
    add_vec(-32'sd45,       1'b0, "967251", 1'b1, "   -45", 1'b0);
    add_vec(32'd0,          1'b0, "000000", 1'b0, "     0", 1'b0);
    add_vec(32'h0000BEEF,   1'b1, "00bEEF", 1'b0, "00bEEF", 1'b0);
    add_vec(32'h10000000,   1'b1, "000000", 1'b1, "000000", 1'b1);
    add_vec(32'd999999,     1'b0, "999999", 1'b0, "999999", 1'b0);
    add_vec(32'd1000000,    1'b0, "000000", 1'b1, "     0", 1'b1);
    add_vec(32'h80000000,   1'b0, "483648", 1'b1, "-83648", 1'b1);
    add_vec(-32'sd123456,   1'b0, "843840", 1'b1, "-23456", 1'b1);
    add_vec(-32'sd7,        1'b0, "967289", 1'b1, "    -7", 1'b0);
    add_vec(32'hFEDCBA98,   1'b1, "dCbA98", 1'b1, "dCbA98", 1'b1);
    add_vec(32'h00123456,   1'b1, "123456", 1'b0, "123456", 1'b0);

    $display("[TB] start");
    set_in(1'b0, 32'd0, 1'b0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_hex", bu.hex, "      ");
    check_bit("reset_ovf", bu.ovf, 1'b0);
    check_bit("reset_in_ready", bu.in_ready, 1'b1);
    check_bit("reset_busy", bu.busy, 1'b0);
    check_bit("reset_done", bu.done, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Latency and busy-duration of a single conversion
    apply_stimulus(32'd29, 1'b0);
    busy_cnt  = 0;
    done_edge = -1;
    for (int n = 0; n < 40; n++) begin
      if (n > 0) begin
        @(posedge clk);
        #1;
      end
      if (bu.busy) busy_cnt++;
      if (bu.done && done_edge < 0) done_edge = n;
      if (n == 32) check_output("lat_hex_before_update", bu.hex, "      ");
      if (n == 33) begin
        check_output("lat_hex_u", bu.hex, "000029");
        check_bit("lat_ovf", bu.ovf, 1'b0);
        check_bit("lat_ready_on_done", bu.in_ready, 1'b1);
      end
      if (n == 34) check_bit("lat_done_width", bu.done, 1'b0);
    end
    check_int("lat_done_edge", done_edge, 33);
    check_int("lat_busy_cycles", busy_cnt, 33);

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].data, vecs[i].hx);
      wait_done($sformatf("vec%0d", i));
      check_output($sformatf("vec%0d_hex_u", i), bu.hex, vecs[i].exp_u);
      check_bit($sformatf("vec%0d_ovf_u", i), bu.ovf, vecs[i].ovf_u);
      check_output($sformatf("vec%0d_hex_s", i), bs.hex, vecs[i].exp_s);
      check_bit($sformatf("vec%0d_ovf_s", i), bs.ovf, vecs[i].ovf_s);
    end

    // A request arriving mid-conversion is dropped, not queued
    apply_stimulus(32'd1234567, 1'b0);
    repeat (9) @(negedge clk);
    set_in(1'b1, 32'd5, 1'b0);
    @(negedge clk);
    set_in(1'b0, 32'd0, 1'b0);
    wait_done("ignore");
    check_output("ignore_hex_u", bu.hex, "234567");
    check_bit("ignore_ovf_u", bu.ovf, 1'b1);
    @(posedge clk);
    #1;
    check_bit("ignore_no_queue", bu.in_ready, 1'b1);

    // Reset in the middle of a conversion discards it
    apply_stimulus(32'd77, 1'b0);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_output("midrst_hex_u", bu.hex, "      ");
    check_output("midrst_hex_s", bs.hex, "      ");
    check_bit("midrst_ovf", bu.ovf, 1'b0);
    check_bit("midrst_in_ready", bu.in_ready, 1'b1);
    check_bit("midrst_busy", bu.busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    apply_stimulus(32'd123, 1'b0);
    wait_done("post_rst");
    check_output("post_rst_hex_u", bu.hex, "000123");
    check_output("post_rst_hex_s", bs.hex, "   123");
    check_bit("post_rst_ovf", bu.ovf, 1'b0);

    // Back-to-back requests with in_valid held high
    @(negedge clk);
    set_in(1'b1, 32'd1, 1'b0);
    @(posedge clk);
    #1;
    set_in(1'b1, 32'd2, 1'b0);
    ndone     = 0;
    prev_done = 1'b0;
    done_at   = '{-1, -1, -1};
    for (int n = 1; n < 200 && ndone < 3; n++) begin
      @(posedge clk);
      #1;
      if (prev_done && ndone == 1) set_in(1'b1, 32'd3, 1'b0);
      prev_done = bu.done;
      if (bu.done) begin
        done_at[ndone] = n;
        ndone++;
        if (ndone == 3) set_in(1'b0, 32'd0, 1'b0);
      end
    end
    set_in(1'b0, 32'd0, 1'b0);
    check_int("b2b_done_count", ndone, 3);
    check_int("b2b_first_done", done_at[0], 33);
    check_int("b2b_spacing_1", done_at[1] - done_at[0], 34);
    check_int("b2b_spacing_2", done_at[2] - done_at[1], 34);
    check_output("b2b_hex_u", bu.hex, "000003");
    check_output("b2b_hex_s", bs.hex, "     3");
    check_bit("b2b_ovf", bu.ovf, 1'b0);
    @(posedge clk);
    #1;
    check_bit("b2b_idle_after", bu.in_ready, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
